fast_domain_1: RTL

Fast-domain receiver for the periodic single-cycle strobe `sig1` produced by the slow-domain pulse generator.
- Synchronizes `sig1` into `clk2` and rising-edge detects it into a one-`clk2`-cycle pulse.
- Measures the `clk2`-cycle spacing between consecutive strobes and flags spacing errors and loss of strobe.
- Sits at the `clk2` side of the slow→fast crossing; feeds fast-domain control and status logic.

---
 rtl/fast_domain_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 55 +++++
 rtl/fast_domain_1.sv | 116 +++++++++++
 3 files changed

// File: rtl/fast_domain_pkg.sv
// Shared types and default constants for the fast-domain strobe receiver.
package fast_domain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;
    localparam int PER_MIN_DEF     = 16;
    localparam int PER_MAX_DEF     = 200;
    localparam int PCNT_W          = 8;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the slow-domain strobe and emits a registered one-cycle rising-edge pulse.
// Optional glitch filter: FAST_DOMAIN_1_GLITCH_FILT_EN (level must persist 2 cycles).
module sync_edge_det
    import fast_domain_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   hist_q;
    logic                   pulse_q;
    logic                   synced;
    logic                   lvl_d;

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef FAST_DOMAIN_1_GLITCH_FILT_EN
    logic filt_q;
    assign lvl_d = synced & filt_q;
`else
    assign lvl_d = synced;
`endif

    // rise_o is the next-cycle value of pulse_o, so the top can register status alongside it
    assign rise_o  = lvl_q & ~hist_q;
    assign pulse_o = pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            lvl_q   <= 1'b0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
`ifdef FAST_DOMAIN_1_GLITCH_FILT_EN
            filt_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            lvl_q   <= lvl_d;
            hist_q  <= lvl_q;
            pulse_q <= rise_o;
`ifdef FAST_DOMAIN_1_GLITCH_FILT_EN
            filt_q  <= synced;
`endif
        end
    end

endmodule

// File: rtl/fast_domain_1.sv
// Fast-domain strobe receiver: edge detect, period measurement, short-period and loss detection.
// Optional glitch filter in sync_edge_det via FAST_DOMAIN_1_GLITCH_FILT_EN.
module fast_domain_1
    import fast_domain_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PER_MIN     = PER_MIN_DEF,
    parameter int PER_MAX     = PER_MAX_DEF
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              sig1,
    output logic              sig1_p,
    output logic [CNT_W-1:0]  period,
    output logic              period_vld,
    output logic              per_err,
    output logic              timeout,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0]  EL_MAX    = '1;
    localparam logic [CNT_W-1:0]  PER_MIN_C = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0]  PER_MAX_C = CNT_W'(PER_MAX);
    localparam logic [PCNT_W-1:0] PCNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   el_q, el_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_vld_q, period_vld_d;
    logic               per_err_q, per_err_d;
    logic               timeout_q, timeout_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic               rise;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk2),
        .rst_i  (rst),
        .sig_i  (sig1),
        .rise_o (rise),
        .pulse_o(sig1_p)
    );

    always_comb begin
        state_d      = state_q;
        el_d         = el_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        per_err_d    = 1'b0;
        timeout_d    = timeout_q;
        pcnt_d       = pcnt_q;

        // el_d is the value el will show in the cycle sig1_p is high, i.e. the period
        if (sig1_p) begin
            el_d = CNT_W'(1);
        end else if (state_q == RUN && el_q != EL_MAX) begin
            el_d = el_q + CNT_W'(1);
        end

        if (rise && pcnt_q != PCNT_MAX) begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rise) state_d = RUN;
            end
            RUN: begin
                if (rise) begin
                    period_d     = el_d;
                    period_vld_d = 1'b1;
                    per_err_d    = (el_d < PER_MIN_C);
                end else if (el_d == PER_MAX_C) begin
                    state_d   = LOST;
                    timeout_d = 1'b1;
                end
            end
            LOST: begin
                if (rise) begin
                    state_d   = RUN;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q      <= IDLE;
            el_q         <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            per_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            pcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            el_q         <= el_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            per_err_q    <= per_err_d;
            timeout_q    <= timeout_d;
            pcnt_q       <= pcnt_d;
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign per_err    = per_err_q;
    assign timeout    = timeout_q;
    assign pulse_cnt  = pcnt_q;

endmodule
